// File: rtl/spi_slave_responder.sv
// ---------------------------------------------------------------------------
// spi_slave_responder
//
// This block is an SPI mode-0 target (CPOL=0, CPHA=0) that transfers bytes MSB first.
// It oversamples the external SCLK, CS and SDI pins on clk. Each received
// byte is delivered to the host. Each transmitted byte comes from a one-deep
// pending slot. When no response byte is pending at a byte boundary, the
// block sends IDLE_BYTE.
//
// Parameters
//   IDLE_BYTE    fill byte sent when nothing is pending at a byte boundary
//   SYNC_STAGES  synchronizer depth on SCLK/CS/SDI (legal range 2..3)
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   SCLK, CS, SDI     asynchronous SPI pins from the master (CS active low)
//   SDO               registered serial data back to the master
//   tx_data, tx_load  host response byte and its load strobe
//   tx_ready          pending slot empty
//   rx_data, rx_valid last complete received byte, one-cycle update pulse
//   frame_error       one-cycle pulse when CS rises in the middle of a byte
//   busy              high while a transaction is in progress
//   state_dbg         current FSM state (0 = IDLE, 1 = ACTIVE)
//
// Transmit handshake: tx_ready is high exactly when the pending slot is
// empty. A cycle with tx_load=1 and tx_ready=1 transfers tx_data into the
// slot. A cycle with tx_load=1 and tx_ready=0 is dropped, and the held byte
// is not changed. The slot is emptied when a byte boundary consumes it.
// ---------------------------------------------------------------------------
module spi_slave_responder #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       SDI,
  output logic       SDO,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy,
  output logic       state_dbg
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [1:0] SETTLE_MAX = 2'(SYNC_STAGES);

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic sclk_s, cs_s, sdi_s;
  logic sclk_d, cs_d;
  logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

  logic [1:0] settle;
  logic       armed;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       boundary;
  logic       pending;
  logic [7:0] hold;

  logic       start, stop, rise_act, fall_act, consume, load_ok;
  logic [7:0] next_byte;

  // Synchronizers and registered edge pulses. Registering the pulses gives
  // SYNC_STAGES+1 cycles from pin to pulse and SYNC_STAGES+2 to SDO.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync   <= '0;
      cs_sync     <= '1;
      sdi_sync    <= '0;
      sclk_d      <= 1'b0;
      cs_d        <= 1'b1;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], CS};
      sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], SDI};
      sclk_d      <= sclk_s;
      cs_d        <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_d;
      sclk_fall_q <= ~sclk_s & sclk_d;
      cs_rise_q   <= cs_s & ~cs_d;
      cs_fall_q   <= ~cs_s & cs_d;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];

  // After reset the synchronizer holds CS=1 no matter what the pin is doing.
  // If the pin is already low, flushing the synchronizer would look like a
  // falling edge. A CS fall is therefore only accepted after CS has been
  // seen high once the pipeline has flushed. This forces a fresh
  // transaction after a mid-frame reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != SETTLE_MAX) settle <= settle + 2'd1;
      if (settle == SETTLE_MAX && cs_s) armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state and per-cycle event decode
  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    rise_act   = 1'b0;
    fall_act   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall_q && armed) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise_q) begin
          stop       = 1'b1;
          state_next = IDLE;
        end else begin
          rise_act = sclk_rise_q;
          fall_act = sclk_fall_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A consume reads the slot as it was before this cycle. A load landing in
  // the same cycle therefore waits for the following boundary.
  assign consume   = start | (fall_act & boundary);
  assign load_ok   = tx_load & ~pending;
  assign next_byte = pending ? hold : IDLE_BYTE;

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      SDO         <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'd0;
      boundary    <= 1'b0;
      pending     <= 1'b0;
      hold        <= 8'h00;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;

      if (load_ok) hold <= tx_data;
      if (consume)      pending <= load_ok;
      else if (load_ok) pending <= 1'b1;

      if (start) begin
        tx_shift <= next_byte;
        SDO      <= next_byte[7];
        bit_cnt  <= 3'd0;
        boundary <= 1'b0;
      end else if (stop) begin
        if (bit_cnt != 3'd0) frame_error <= 1'b1;
        bit_cnt  <= 3'd0;
        boundary <= 1'b0;
        SDO      <= 1'b0;
      end else if (rise_act) begin
        rx_shift <= {rx_shift[5:0], sdi_s};
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift, sdi_s};
          rx_valid <= 1'b1;
          bit_cnt  <= 3'd0;
          boundary <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (fall_act) begin
        if (boundary) begin
          tx_shift <= next_byte;
          SDO      <= next_byte[7];
          boundary <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          SDO      <= tx_shift[6];
        end
      end
    end
  end

  assign tx_ready  = ~pending;
  assign busy      = (state == ACTIVE);
  assign state_dbg = state;

endmodule
